// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared encodings and helpers for the sequential multiplier
package mult_pkg;

  localparam int NIBBLE = 4;
  localparam int ACC_W  = 16;

  typedef enum logic [1:0] {
    SEL_LL = 2'b00,
    SEL_LH = 2'b01,
    SEL_HL = 2'b10,
    SEL_HH = 2'b11
  } input_sel_e;

  typedef enum logic [1:0] {
    SH_0 = 2'b00,
    SH_4 = 2'b01,
    SH_8 = 2'b10
  } shift_sel_e;

  // Encoding 2'b11 is reserved and falls through to no shift.
  function automatic logic [ACC_W-1:0] shift_pp(input logic [2*NIBBLE-1:0] pp,
                                                input logic [1:0]          sel);
    logic [ACC_W-1:0] ext;
    ext = {{(ACC_W-2*NIBBLE){1'b0}}, pp};
    case (sel)
      SH_4:    shift_pp = ext << NIBBLE;
      SH_8:    shift_pp = ext << (2*NIBBLE);
      default: shift_pp = ext;
    endcase
  endfunction

endpackage

// File: rtl/mult4x4.sv
// rtl/mult4x4.sv - combinational 4x4 unsigned nibble multiplier
module mult4x4
  import mult_pkg::*;
(
  input  logic [NIBBLE-1:0]   a,
  input  logic [NIBBLE-1:0]   b,
  output logic [2*NIBBLE-1:0] p
);

  assign p = {{NIBBLE{1'b0}}, a} * {{NIBBLE{1'b0}}, b};

endmodule

// File: rtl/mult_datapath.sv
// rtl/mult_datapath.sv - operand capture, nibble partial products and accumulator
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_a,
  input  logic             start,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  input  logic [1:0]       input_sel,
  input  logic [1:0]       shift_sel,
  input  logic             clk_ena,
  input  logic             sclr_n,
  input  logic             done,
  output logic [1:0]       count,
  output logic [ACC_W-1:0] product,
  output logic [ACC_W-1:0] result,
  output logic             result_valid
);

  logic [WIDTH-1:0]    opa;
  logic [WIDTH-1:0]    opb;
  logic [NIBBLE-1:0]   nib_a;
  logic [NIBBLE-1:0]   nib_b;
  logic [2*NIBBLE-1:0] pp;
  logic [ACC_W-1:0]    pp_shifted;
  logic [ACC_W-1:0]    acc;

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      opa <= '0;
      opb <= '0;
    end else if (start) begin
      opa <= dataa;
      opb <= datab;
    end
  end

  always_comb begin
    nib_a = opa[NIBBLE-1:0];
    nib_b = opb[NIBBLE-1:0];
    case (input_sel)
      SEL_LH: nib_b = opb[2*NIBBLE-1:NIBBLE];
      SEL_HL: nib_a = opa[2*NIBBLE-1:NIBBLE];
      SEL_HH: begin
        nib_a = opa[2*NIBBLE-1:NIBBLE];
        nib_b = opb[2*NIBBLE-1:NIBBLE];
      end
      default: ;
    endcase
  end

  mult4x4 u_mult4x4 (
    .a (nib_a),
    .b (nib_b),
    .p (pp)
  );

  assign pp_shifted = shift_pp(pp, shift_sel);

  // Clear beats accumulate so the controller can flush during start.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      acc <= '0;
    end else if (!sclr_n) begin
      acc <= '0;
    end else if (clk_ena) begin
      acc <= acc + pp_shifted;
    end
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else begin
      count <= count + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= done;
      if (done) begin
        result <= acc;
      end
    end
  end

  assign product = acc;

endmodule

// File: doc/mult_datapath.md
# mult_datapath

Arithmetic datapath for the 8-bit sequential multiplier, driven by the multiplier control FSM. It captures two 8-bit operands on `start` and forms one 4x4 nibble partial product per cycle, selected by `input_sel`. Each partial product is shifted per `shift_sel` and accumulated into a 16-bit register. It returns the 2-bit step `count` to the controller and latches the final product when the controller raises `done`.

## Interface
Parameters:
- `WIDTH`, 8: operand width. Only 8 is supported; fixed nibble size 4.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `reset_a`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin new multiply: capture operands, clear counter.
- `dataa`  in  8  multiplicand, sampled when `start`=1.
- `datab`  in  8  multiplier, sampled when `start`=1.
- `input_sel`  in  2  nibble-pair select from controller.
- `shift_sel`  in  2  partial-product shift select from controller.
- `clk_ena`  in  1  accumulate enable from controller.
- `sclr_n`  in  1  synchronous accumulator clear, active-low.
- `done`  in  1  controller completion strobe.
- `count`  out  2  step counter, fed back to controller.
- `product`  out  16  live accumulator value.
- `result`  out  16  product held from last completed multiply.
- `result_valid`  out  1  one-cycle pulse when `result` updates.

## Operation
- Operand capture: `start`=1 → `opa`<=`dataa`, `opb`<=`datab`. Otherwise hold.
- Nibble select, combinational on captured operands:
  - 00: `opa[3:0]`×`opb[3:0]`
  - 01: `opa[3:0]`×`opb[7:4]`
  - 10: `opa[7:4]`×`opb[3:0]`
  - 11: `opa[7:4]`×`opb[7:4]`
  - Result is 8-bit, zero-extended to 16 bits.
- Shift: 00 → <<0; 01 → <<4; 10 → <<8; 11 → <<0 (reserved, treated as no shift).
- Accumulator, priority order:
  - `sclr_n`=0 → acc<=0, irrespective of `clk_ena`.
  - else `clk_ena`=1 → acc<=acc+shifted partial product, 16-bit modulo 2^16.
  - else hold.
  - A correct 4-step sequence cannot overflow.
- Counter: `start`=1 → count<=0. Otherwise count<=count+1 every cycle, wrapping 3→0.
- Result: `done`=1 → `result`<=acc and `result_valid`<=1 next cycle. Otherwise `result_valid`<=0 and `result` holds.
- `product` = acc directly, no extra register.

## Timing
- Reset values: `opa`, `opb`, acc, `product`, `result` = 0; `count` = 0; `result_valid` = 0.
- Reset is asynchronous and applies immediately mid-operation. Any partial accumulation is lost; `result` returns to 0.
- Accumulate latency: the partial product selected in cycle N appears on `product` after edge N+1.
- `start` held for multiple cycles: operands re-captured and count held at 0 each cycle.
- `start` wins over count increment.
- `start` and `sclr_n`=0 in the same cycle are legal: both clears take effect.
- `done` in the same cycle as an accumulating `clk_ena`: `result` takes the pre-add acc value. The controller never overlaps these.
- `done` asserted with `start`: `result` still captures acc, and `result_valid` pulses.
- Back-to-back `done` cycles: `result_valid` stays high for each cycle and `result` re-captures each cycle.

## Structure
- Shared package `mult_pkg`:
  - `input_sel` encodings: `SEL_LL`, `SEL_LH`, `SEL_HL`, `SEL_HH`.
  - `shift_sel` encodings: `SH_0`, `SH_4`, `SH_8`.
  - `NIBBLE`=4, `ACC_W`=16.
  - Used by both `mult_control` and this block.
- One sub-module `mult4x4`: combinational 4×4→8 unsigned multiplier, instantiated once after the nibble muxes.
- Counter, shifter, adder and registers live in the top.

## Test plan
- Reset mid-accumulation (acc=0x0123, `reset_a` pulsed low) → `product`, `result`, `count`, `result_valid` all 0 asynchronously, before the next clock edge.
- `start` with a=0x12, b=0x34, then steps (`input_sel`,`shift_sel`) = (00,00), (01,01), (10,01), (11,10) with `clk_ena`=1, `sclr_n`=0 only in the `start` cycle → `product` sequence 0x0008, 0x0068, 0x00A8, 0x03A8. `done` then gives `result`=0x03A8 and a one-cycle `result_valid`.
- a=0xFF, b=0xFF, same sequence → `product` = 0xFE01; no wrap.
- `clk_ena`=0 for 2 cycles between steps → `product` holds; `count` keeps incrementing and wraps 3→0.
- `start` held 3 cycles while `dataa` changes 0x10→0x20→0x30 → `count` stays 0 and the captured operand is 0x30.
- `sclr_n`=0 together with `clk_ena`=1 and acc=0x00A8 → acc=0 next cycle; no add occurs.
